spi_master_cfg: RTL and testbench

Parametrised successor to the team's fixed 7-bit SPI master. Full-duplex SPI controller with configurable word width, SCLK divider, SPI mode (CPOL/CPHA) and bit order. Transmits a parallel word on MOSI while capturing MISO into a parallel receive word. Sits between the system-side command logic and an external SPI peripheral (e.g. the LCD), using a single system clock.

---
 rtl/spi_master_cfg.sv | 154 +++++++++++++++
 tb/tb_spi_master_cfg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable word width, SCLK divider, CPOL/CPHA and bit order.
// All outputs are registered; one transfer is SETUP, 2N SCLK half-periods, HOLD, then a done pulse.
//
// state   | meaning
// S_IDLE  | SS high, waiting for send; also the completion cycle that pulses done
// S_SETUP | SS low for CLK_DIV cycles before the first SCLK edge
// S_XFER  | 2*DATA_WIDTH SCLK half-periods of CLK_DIV cycles each
// S_HOLD  | SCLK back at idle level, SS still low for CLK_DIV cycles
module spi_master_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter bit CPOL       = 1'b0,
   parameter bit CPHA       = 1'b0,
   parameter bit LSB_FIRST  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  send,
   input  logic                  MISO,
   output logic                  MOSI,
   output logic                  SCLK,
   output logic                  SS,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [7:0] DIV_M1    = 8'(CLK_DIV - 1);
   localparam logic [6:0] HALF_LAST = 7'(2 * DATA_WIDTH);

   logic [1:0]            r_state;
   logic [7:0]            r_cnt;
   logic [6:0]            r_half;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_mosi;
   logic                  r_sclk;
   logic                  r_ss;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_tx_first;
   logic [DATA_WIDTH-1:0] w_tx_shift;
   logic                  w_din_first;
   logic [DATA_WIDTH-1:0] w_din_shift;
   logic [DATA_WIDTH-1:0] w_rx_next;
   logic [6:0]            w_half_next;
   logic                  w_lead;
   logic                  w_sample;
   logic                  w_shift;

   assign w_tx_first  = LSB_FIRST ? r_tx[0] : r_tx[DATA_WIDTH-1];
   assign w_tx_shift  = LSB_FIRST ? (r_tx >> 1) : (r_tx << 1);
   assign w_din_first = LSB_FIRST ? data_in[0] : data_in[DATA_WIDTH-1];
   assign w_din_shift = LSB_FIRST ? (data_in >> 1) : (data_in << 1);
   assign w_rx_next   = LSB_FIRST ? {MISO, r_rx[DATA_WIDTH-1:1]}
                                  : {r_rx[DATA_WIDTH-2:0], MISO};

   // Odd half-periods open with the leading edge; the edge type decides sample vs shift.
   assign w_half_next = r_half + 7'd1;
   assign w_lead      = w_half_next[0];
   assign w_sample    = CPHA ? ~w_lead : w_lead;
   assign w_shift     = ~w_sample && !(!CPHA && (w_half_next == HALF_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_half  <= '0;
         r_tx    <= '0;
         r_rx    <= '0;
         r_dout  <= '0;
         r_mosi  <= 1'b0;
         r_sclk  <= CPOL;
         r_ss    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_ss   <= 1'b1;
               r_busy <= 1'b0;
               r_mosi <= 1'b0;
               r_sclk <= CPOL;
               if (send) begin
                  r_state <= S_SETUP;
                  r_ss    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_cnt   <= DIV_M1;
                  r_half  <= '0;
                  r_rx    <= '0;
                  // CPHA=0 must present the first bit before the first (sampling) edge.
                  if (!CPHA) begin
                     r_mosi <= w_din_first;
                     r_tx   <= w_din_shift;
                  end else begin
                     r_mosi <= 1'b0;
                     r_tx   <= data_in;
                  end
               end
            end
            S_SETUP, S_XFER: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else if (r_half == HALF_LAST) begin
                  r_state <= S_HOLD;
                  r_cnt   <= DIV_M1;
               end else begin
                  r_state <= S_XFER;
                  r_cnt   <= DIV_M1;
                  r_half  <= w_half_next;
                  r_sclk  <= ~r_sclk;
                  if (w_sample) begin
                     r_rx <= w_rx_next;
                  end
                  if (w_shift) begin
                     r_mosi <= w_tx_first;
                     r_tx   <= w_tx_shift;
                  end
               end
            end
            S_HOLD: begin
               if (r_cnt != 8'd0) begin
                  r_cnt <= r_cnt - 8'd1;
               end else begin
                  r_state <= S_IDLE;
                  r_ss    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_dout  <= r_rx;
                  r_mosi  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign MOSI     = r_mosi;
   assign SCLK     = r_sclk;
   assign SS       = r_ss;
   assign busy     = r_busy;
   assign done     = r_done;
   assign data_out = r_dout;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: four parameter sets, a done-driven scoreboard and a per-cycle
// protocol monitor that rebuilds the transmitted word from MOSI at the observed sample edges.
module tb_spi_master_cfg;

   localparam int NW   [4] = '{8, 8, 7, 2};
   localparam int DV   [4] = '{2, 2, 3, 1};
   localparam bit POL  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   localparam bit PHA  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   localparam bit LSBF [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   typedef struct {
      int          k;
      logic [31:0] tx;
      logic [31:0] rx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] send;
   logic       miso_c;
   logic [7:0] din_a, din_b;
   logic [6:0] din_c;
   logic [1:0] din_d;
   wire  [3:0] mosi, sclk, ss, busy, done, miso;
   wire  [7:0] dout_a, dout_b;
   wire  [6:0] dout_c;
   wire  [1:0] dout_d;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   int          ss_run [4];
   int          lead_cnt [4];
   int          smp_cnt [4];
   bit          run_ok [4];
   logic        p_ss [4];
   logic        p_sclk [4];
   logic        p_mosi [4];
   logic [31:0] tx_obs [4];

   always #5 clk = ~clk;

   assign miso[0] = mosi[0];
   assign miso[1] = 1'b1;
   assign miso[2] = miso_c;
   assign miso[3] = 1'b0;

   spi_master_cfg #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u_a (
      .clk(clk), .rst(rst), .data_in(din_a), .send(send[0]), .MISO(miso[0]), .MOSI(mosi[0]),
      .SCLK(sclk[0]), .SS(ss[0]), .busy(busy[0]), .done(done[0]), .data_out(dout_a));
   spi_master_cfg #(.DATA_WIDTH(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .data_in(din_b), .send(send[1]), .MISO(miso[1]), .MOSI(mosi[1]),
      .SCLK(sclk[1]), .SS(ss[1]), .busy(busy[1]), .done(done[1]), .data_out(dout_b));
   spi_master_cfg #(.DATA_WIDTH(7), .CLK_DIV(3), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst), .data_in(din_c), .send(send[2]), .MISO(miso[2]), .MOSI(mosi[2]),
      .SCLK(sclk[2]), .SS(ss[2]), .busy(busy[2]), .done(done[2]), .data_out(dout_c));
   spi_master_cfg #(.DATA_WIDTH(2), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_d (
      .clk(clk), .rst(rst), .data_in(din_d), .send(send[3]), .MISO(miso[3]), .MOSI(mosi[3]),
      .SCLK(sclk[3]), .SS(ss[3]), .busy(busy[3]), .done(done[3]), .data_out(dout_d));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_dout(input int k);
      case (k)
         0:       return 32'(dout_a);
         1:       return 32'(dout_b);
         2:       return 32'(dout_c);
         3:       return 32'(dout_d);
         default: return 32'd0;
      endcase
   endfunction

   // Waits for done on instance k; start is the cycle number of the previous negedge.
   task automatic wait_done(input int k, input int start, input int exp_cycle);
      int c;
      c = start;
      do begin
         @(negedge clk);
         c++;
      end while (!done[k] && c < start + 3000);
      chk($sformatf("done_cycle_%0d", k), done[k] ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_cycle));
   endtask

   task automatic xfer(input int k, input logic [31:0] d, input logic [31:0] rx_exp);
      case (k)
         0:       din_a = d[7:0];
         1:       din_b = d[7:0];
         2:       din_c = d[6:0];
         default: din_d = d[1:0];
      endcase
      sb.push_back('{k: k, tx: d, rx: rx_exp});
      send[k] = 1'b1;
      @(posedge clk);
      #1 send[k] = 1'b0;
      wait_done(k, 0, 1 + DV[k] * (2 * NW[k] + 2));
   endtask

   always @(negedge clk) begin : mon
      logic chg, to_lead, to_samp, to_shift;
      int   sh;
      exp_t e;
      if (mon_en) begin
         for (int k = 0; k < 4; k++) begin
            chg      = (sclk[k] != p_sclk[k]);
            to_lead  = chg && (sclk[k] != POL[k]);
            to_samp  = chg && (PHA[k] ? !to_lead : to_lead);
            to_shift = chg && !to_samp;
            if (rst) run_ok[k] = 1'b0;
            chk($sformatf("busy_vs_ss_%0d", k), 32'(busy[k]), 32'(!ss[k]));
            if (ss[k]) begin
               chk($sformatf("idle_sclk_%0d", k), 32'(sclk[k]), 32'(POL[k]));
               chk($sformatf("idle_mosi_%0d", k), 32'(mosi[k]), 32'd0);
            end
            if (!ss[k] && p_ss[k]) begin
               run_ok[k]   = 1'b1;
               ss_run[k]   = 1;
               lead_cnt[k] = 0;
               smp_cnt[k]  = 0;
               tx_obs[k]   = 32'd0;
            end else if (!ss[k]) begin
               ss_run[k]++;
               if (to_lead) lead_cnt[k]++;
               if (to_samp) begin
                  if (smp_cnt[k] < NW[k]) begin
                     sh = LSBF[k] ? smp_cnt[k] : NW[k] - 1 - smp_cnt[k];
                     tx_obs[k] = tx_obs[k] | (32'(mosi[k]) << sh);
                  end
                  smp_cnt[k]++;
               end
               if (mosi[k] != p_mosi[k])
                  chk($sformatf("mosi_on_shift_edge_%0d", k), 32'(to_shift), 32'd1);
            end
            if (ss[k] && !p_ss[k] && run_ok[k]) begin
               chk($sformatf("ss_low_len_%0d", k), 32'(ss_run[k]), 32'(DV[k] * (2 * NW[k] + 2)));
               chk($sformatf("sclk_periods_%0d", k), 32'(lead_cnt[k]), 32'(NW[k]));
               chk($sformatf("done_at_ss_rise_%0d", k), 32'(done[k]), 32'd1);
            end
            if (done[k]) begin
               chk($sformatf("done_after_run_%0d", k), 32'(run_ok[k]), 32'd1);
               if (sb.size() == 0) begin
                  chk($sformatf("done_expected_%0d", k), 32'd0, 32'd1);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("done_instance_%0d", k), 32'(e.k), 32'(k));
                  chk($sformatf("data_out_%0d", k), get_dout(k), e.rx);
                  chk($sformatf("mosi_word_%0d", k), tx_obs[k], e.tx);
               end
               run_ok[k] = 1'b0;
            end
            p_ss[k]   = ss[k];
            p_sclk[k] = sclk[k];
            p_mosi[k] = mosi[k];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      send   = 4'b0;
      miso_c = 1'b0;
      din_a  = 8'h00;
      din_b  = 8'h00;
      din_c  = 7'h00;
      din_d  = 2'b00;
      for (int k = 0; k < 4; k++) begin
         p_ss[k]   = 1'b1;
         p_sclk[k] = POL[k];
         p_mosi[k] = 1'b0;
         run_ok[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_ss_%0d", k), 32'(ss[k]), 32'd1);
         chk($sformatf("rst_sclk_%0d", k), 32'(sclk[k]), 32'(POL[k]));
         chk($sformatf("rst_mosi_%0d", k), 32'(mosi[k]), 32'd0);
         chk($sformatf("rst_busy_%0d", k), 32'(busy[k]), 32'd0);
         chk($sformatf("rst_done_%0d", k), 32'(done[k]), 32'd0);
         chk($sformatf("rst_dout_%0d", k), get_dout(k), 32'd0);
      end
      mon_en = 1'b1;

      // Mode 0, loopback
      @(posedge clk); #1;
      xfer(0, 32'hA5, 32'hA5);
      repeat (5) @(negedge clk);
      chk("dout_hold_a", get_dout(0), 32'hA5);

      // Mode 3, MISO high
      @(posedge clk); #1;
      xfer(1, 32'h3C, 32'hFF);

      // LSB first, N=7, D=3, MISO 1 on the first sample only
      @(posedge clk); #1;
      din_c  = 7'h31;
      miso_c = 1'b1;
      sb.push_back('{k: 2, tx: 32'h31, rx: 32'h01});
      send[2] = 1'b1;
      @(posedge clk);
      #1 send[2] = 1'b0;
      repeat (3) @(posedge clk);
      #1 miso_c = 1'b0;
      wait_done(2, 3, 49);

      // N=2, D=1, mode 1, send held high for two back-to-back transfers
      @(posedge clk); #1;
      din_d = 2'b10;
      sb.push_back('{k: 3, tx: 32'h2, rx: 32'h0});
      sb.push_back('{k: 3, tx: 32'h2, rx: 32'h0});
      send[3] = 1'b1;
      @(posedge clk); #1;
      wait_done(3, 0, 7);
      chk("held_send_ss_high", 32'(ss[3]), 32'd1);
      @(posedge clk);
      #1 send[3] = 1'b0;
      wait_done(3, 0, 7);

      // Mid-transfer send ignored, data_in change ignored, send at completion accepted
      @(posedge clk); #1;
      din_a = 8'h5A;
      sb.push_back('{k: 0, tx: 32'h5A, rx: 32'h5A});
      send[0] = 1'b1;
      @(posedge clk);
      #1 send[0] = 1'b0;
      repeat (9) @(posedge clk);
      #1 send[0] = 1'b1;
      din_a = 8'hC3;
      @(posedge clk);
      #1 send[0] = 1'b0;
      wait_done(0, 10, 37);
      chk("b2b_ss_high_at_done", 32'(ss[0]), 32'd1);
      sb.push_back('{k: 0, tx: 32'hC3, rx: 32'hC3});
      send[0] = 1'b1;
      @(posedge clk);
      #1 send[0] = 1'b0;
      @(negedge clk);
      chk("b2b_ss_low_next", 32'(ss[0]), 32'd0);
      chk("b2b_busy_next", 32'(busy[0]), 32'd1);
      wait_done(0, 1, 37);

      // Reset in cycle 15 of a transfer
      @(posedge clk); #1;
      din_a   = 8'hFF;
      send[0] = 1'b1;
      @(posedge clk);
      #1 send[0] = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ss", 32'(ss[0]), 32'd1);
      chk("abort_sclk", 32'(sclk[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_mosi", 32'(mosi[0]), 32'd0);
      chk("abort_done", 32'(done[0]), 32'd0);
      chk("abort_dout", get_dout(0), 32'd0);
      repeat (60) @(negedge clk);
      chk("abort_still_idle", 32'(ss[0]), 32'd1);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
